// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: default cycle counts
// for a 25 MHz clock and the channel order used when wiring to the menu.
package btn_pkg;

    localparam int unsigned CLK_HZ             = 25_000_000;
    localparam int unsigned DEBOUNCE_10MS      = CLK_HZ / 100;
    localparam int unsigned REPEAT_DELAY_500MS = CLK_HZ / 2;
    localparam int unsigned REPEAT_RATE_100MS  = CLK_HZ / 10;

    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_BACK   = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the menu stage: raw levels in,
// debounced level and one-cycle press/release pulses out.
interface button_conditioner_if #(
    parameter int unsigned NUM_BTN = 4
);

    logic [NUM_BTN-1:0] btn_raw_i;
    logic [NUM_BTN-1:0] btn_level_o;
    logic [NUM_BTN-1:0] btn_press_o;
    logic [NUM_BTN-1:0] btn_release_o;

    modport master (
        output btn_raw_i,
        input  btn_level_o,
        input  btn_press_o,
        input  btn_release_o
    );

    modport slave (
        input  btn_raw_i,
        output btn_level_o,
        output btn_press_o,
        output btn_release_o
    );

endinterface

// File: rtl/btn_debounce_chan.sv
// One button channel: two-flop synchronizer, debounce filter, registered
// press/release pulses and, with BTN_AUTOREPEAT_EN defined, hold-to-repeat.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY_CYCLES = REPEAT_DELAY_500MS,
    parameter int unsigned REPEAT_RATE_CYCLES  = REPEAT_RATE_100MS
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Repeat pulses must be separated by low cycles to look like fresh edges.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 2) begin : g_bad_cfg
        $error("btn_debounce_chan: invalid cycle parameters");
    end

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            rpt_tick;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sync1_d  = btn_raw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // The level is registered once more so the pulses line up with it.
    always_comb begin
        level_d   = stable_q;
        press_d   = (stable_q & ~level_q) | rpt_tick;
        release_d = ~stable_q & level_q;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_last;
    logic             held;

    always_comb begin
        held        = level_q & stable_q;
        rpt_last    = rpt_first_q ? RPT_DELAY_LAST : RPT_RATE_LAST;
        rpt_tick    = held & (rpt_cnt_q == rpt_last);
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        // Not held covers idle, the press edge itself and the release edge.
        if (!held) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_tick) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end else begin
            rpt_cnt_d   = rpt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_tick = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw push-buttons into clean synchronous levels and pulses
// for the menu stage; hold-to-repeat is compiled in with BTN_AUTOREPEAT_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN             = 4,
    parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY_CYCLES = REPEAT_DELAY_500MS,
    parameter int unsigned REPEAT_RATE_CYCLES  = REPEAT_RATE_100MS
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    button_conditioner_if.slave  btn_if
);

    // Channel i serves bit i; BTN_UP/BTN_DOWN land on the menu select inputs.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
        ) u_chan (
            .clk_i         (clk_i),
            .reset_ni      (reset_ni),
            .btn_raw_i     (btn_if.btn_raw_i[i]),
            .btn_level_o   (btn_if.btn_level_o[i]),
            .btn_press_o   (btn_if.btn_press_o[i]),
            .btn_release_o (btn_if.btn_release_o[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared against a sample-window reference model.
module tb_button_conditioner;

    localparam int NB  = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
    localparam int LAT = 2 + DEB;
    localparam int H   = DEB + 2;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk_i;
    logic reset_ni;
    int   checks;
    int   errors;

    button_conditioner_if #(.NUM_BTN(NB)) bus ();

    button_conditioner #(
        .NUM_BTN             (NB),
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_RATE_CYCLES  (RR)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .btn_if   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: a button is accepted once the DEB samples taken two to
    // DEB+1 edges ago all disagree with the accepted state; outputs lag a cycle.
    logic [NB-1:0] hist_m [H];
    logic [NB-1:0] stable_m, level_m, press_m, release_m;
    int            hold_m [NB];

    always @(posedge clk_i or negedge reset_ni) begin : model
        logic [NB-1:0] st_prev, lv_prev;
        bit            flip;
        if (!reset_ni) begin
            for (int k = 0; k < H; k++) hist_m[k] = '0;
            stable_m = '0; level_m = '0; press_m = '0; release_m = '0;
            for (int c = 0; c < NB; c++) hold_m[c] = 0;
        end else begin
            st_prev = stable_m;
            lv_prev = level_m;
            for (int k = H - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
            hist_m[0] = bus.btn_raw_i;
            level_m   = st_prev;
            press_m   = st_prev & ~lv_prev;
            release_m = ~st_prev & lv_prev;
            for (int c = 0; c < NB; c++) begin
                if (st_prev[c] && lv_prev[c]) begin
                    hold_m[c]++;
                    if (AUTOREP && (hold_m[c] == RD || (hold_m[c] > RD && (hold_m[c] - RD) % RR == 0)))
                        press_m[c] = 1'b1;
                end else begin
                    hold_m[c] = 0;
                end
                flip = 1'b1;
                for (int k = 2; k < H; k++)
                    if (hist_m[k][c] == st_prev[c]) flip = 1'b0;
                if (flip) stable_m[c] = ~st_prev[c];
            end
        end
    end

    task automatic test_reset();
        bus.btn_raw_i = 4'b0001;
        reset_ni = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if ({bus.btn_level_o, bus.btn_press_o, bus.btn_release_o} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got %b/%b/%b, expected all zero", k,
                         bus.btn_level_o, bus.btn_press_o, bus.btn_release_o);
            end
        end
        reset_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus.btn_level_o !== ((k >= LAT) ? 4'b0001 : 4'b0000) ||
                bus.btn_press_o !== ((k == LAT) ? 4'b0001 : 4'b0000) || bus.btn_release_o !== 4'b0000) begin
                errors++;
                $display("FAIL reset_held_press edge %0d: level %b press %b release %b, expected level %b press %b", k,
                         bus.btn_level_o, bus.btn_press_o, bus.btn_release_o,
                         (k >= LAT) ? 4'b0001 : 4'b0000, (k == LAT) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_bounce();
        logic v;
        for (int c = 0; c < 20; c++) begin
            bus.btn_raw_i[1] = ((c / 2) % 2) == 0;
            @(negedge clk_i);
            checks++;
            if (bus.btn_level_o !== level_m || bus.btn_press_o !== press_m || bus.btn_level_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_fixed cyc %0d: level %b press %b, expected level %b press %b", c,
                         bus.btn_level_o, bus.btn_press_o, level_m, press_m);
            end
        end
        v = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bus.btn_raw_i[1] = v;
            repeat ($urandom_range(1, DEB - 1)) begin
                @(negedge clk_i);
                checks++;
                if (bus.btn_level_o[1] !== 1'b0 || bus.btn_press_o !== press_m) begin
                    errors++;
                    $display("FAIL bounce_random run %0d: level1 %b press %b, expected level1 0 press %b", r,
                             bus.btn_level_o[1], bus.btn_press_o, press_m);
                end
            end
            v = ~v;
        end
        bus.btn_raw_i[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus.btn_press_o[1] !== (k == LAT) || bus.btn_level_o[1] !== (k >= LAT) ||
                bus.btn_release_o !== release_m) begin
                errors++;
                $display("FAIL bounce_settle edge %0d: press1 %b level1 %b release %b, expected %b %b %b", k,
                         bus.btn_press_o[1], bus.btn_level_o[1], bus.btn_release_o, k == LAT, k >= LAT, release_m);
            end
        end
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 2; g++) begin
            int len;
            len = (g == 0) ? 3 : int'($urandom_range(1, DEB - 1));
            bus.btn_raw_i[1] = 1'b0;
            for (int k = 0; k < len + 10; k++) begin
                if (k == len) bus.btn_raw_i[1] = 1'b1;
                @(negedge clk_i);
                checks++;
                if (bus.btn_level_o[1] !== 1'b1 || bus.btn_release_o[1] !== 1'b0 ||
                    bus.btn_level_o !== level_m) begin
                    errors++;
                    $display("FAIL glitch_len%0d cyc %0d: level %b release %b, expected level %b no release", len, k,
                             bus.btn_level_o, bus.btn_release_o, level_m);
                end
            end
        end
        bus.btn_raw_i[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus.btn_release_o[1] !== (k == LAT) || bus.btn_level_o[1] !== (k < LAT) || bus.btn_press_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL release_latency edge %0d: release1 %b level1 %b press1 %b, expected %b %b 0", k,
                         bus.btn_release_o[1], bus.btn_level_o[1], bus.btn_press_o[1], k == LAT, k < LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.btn_raw_i[3:2] = 2'b11;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus.btn_press_o[3:2] !== ((k == LAT) ? 2'b11 : 2'b00) ||
                bus.btn_level_o[3:2] !== ((k >= LAT) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL dual_press edge %0d: press %b level %b, expected press %b level %b", k,
                         bus.btn_press_o[3:2], bus.btn_level_o[3:2],
                         (k == LAT) ? 2'b11 : 2'b00, (k >= LAT) ? 2'b11 : 2'b00);
            end
        end
        bus.btn_raw_i[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus.btn_level_o[2] !== 1'b1 || bus.btn_release_o[2] !== 1'b0 ||
                bus.btn_release_o[3] !== (k == LAT) || bus.btn_press_o !== press_m) begin
                errors++;
                $display("FAIL single_release edge %0d: level2 %b release %b press %b, expected level2 1 release3 %b press %b",
                         k, bus.btn_level_o[2], bus.btn_release_o, bus.btn_press_o, k == LAT, press_m);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        bus.btn_raw_i[0] = 1'b0;
        repeat (10) @(negedge clk_i);
        checks++;
        if (bus.btn_level_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_prep: level0 %b, expected 0", bus.btn_level_o[0]);
        end
        bus.btn_raw_i[0] = 1'b1;
        repeat (5) @(negedge clk_i);
        reset_ni = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if ({bus.btn_level_o, bus.btn_press_o, bus.btn_release_o} !== 12'h000) begin
                errors++;
                $display("FAIL mid_reset_outputs cyc %0d: got %b/%b/%b, expected all zero", k,
                         bus.btn_level_o, bus.btn_press_o, bus.btn_release_o);
            end
        end
        reset_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus.btn_press_o[0] !== (k == LAT) || bus.btn_level_o[0] !== (k >= LAT) ||
                bus.btn_press_o !== press_m) begin
                errors++;
                $display("FAIL mid_reset_relatency edge %0d: press0 %b level0 %b press %b, expected %b %b %b", k,
                         bus.btn_press_o[0], bus.btn_level_o[0], bus.btn_press_o, k == LAT, k >= LAT, press_m);
            end
        end
    endtask

    task automatic test_autorepeat();
        localparam int HOLD = 36;
        localparam int REL  = HOLD + LAT;
        bit exp_p;
        bus.btn_raw_i[1] = 1'b1;
        for (int k = 0; k < REL + 8; k++) begin
            if (k == HOLD) bus.btn_raw_i[1] = 1'b0;
            @(negedge clk_i);
            exp_p = (k == LAT) ||
                    (AUTOREP && k >= LAT + RD && k < REL && (k - LAT - RD) % RR == 0);
            checks++;
            if (bus.btn_press_o[1] !== exp_p || bus.btn_release_o[1] !== (k == REL) ||
                bus.btn_press_o !== press_m || bus.btn_level_o !== level_m) begin
                errors++;
                $display("FAIL autorepeat edge %0d: press1 %b release1 %b level %b, expected press1 %b release1 %b level %b",
                         k, bus.btn_press_o[1], bus.btn_release_o[1], bus.btn_level_o, exp_p, k == REL, level_m);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 5) == 0) bus.btn_raw_i[b] = ~bus.btn_raw_i[b];
            if (c == 300) reset_ni = 1'b0;
            if (c == 302) reset_ni = 1'b1;
            @(negedge clk_i);
            checks++;
            if (bus.btn_level_o !== level_m || bus.btn_press_o !== press_m ||
                bus.btn_release_o !== release_m || (bus.btn_press_o & bus.btn_release_o) !== 4'b0000) begin
                errors++;
                $display("FAIL random cyc %0d: level %b press %b release %b, expected %b %b %b", c,
                         bus.btn_level_o, bus.btn_press_o, bus.btn_release_o, level_m, press_m, release_m);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        bus.btn_raw_i = '0;
        reset_ni      = 1'b1;
        #1 reset_ni   = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_bounce();
        test_glitch();
        test_back_to_back();
        test_reset_mid_count();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
